// File: rtl/input_arguments_pkg.sv
// cfg_pkg: shared keys, parser states and mode constants for the run-configuration front end
package cfg_pkg;

    typedef enum logic [2:0] {S_START, S_KEY, S_MVAL, S_FVAL, S_SKIP} state_t;

    localparam logic [39:0] KEY_MODE     = "MODE=";
    localparam logic [39:0] KEY_FILE     = "FILE=";
    localparam logic [31:0] MODE_VERBOSE = 32'd1;

    // Byte idx (0 = first character) of a five-character key.
    function automatic logic [7:0] key_byte(input logic [39:0] key, input logic [2:0] idx);
        return key[8*(3'd4 - idx) +: 8];
    endfunction

endpackage

// File: rtl/input_arguments_if.sv
// input_arguments_if: argument byte stream and published configuration
interface input_arguments_if;

    logic        arg_valid;
    logic        arg_ready;
    logic [7:0]  arg_data;
    logic        arg_last;
    logic        args_end;
    logic [31:0] file;
    logic [31:0] mode;
    logic        cfg_valid;
    logic        err;

    modport master (output arg_valid, arg_data, arg_last, args_end,
                    input  arg_ready, file, mode, cfg_valid, err);
    modport slave  (input  arg_valid, arg_data, arg_last, args_end,
                    output arg_ready, file, mode, cfg_valid, err);

endinterface

// File: rtl/input_arguments_dec_accum.sv
// dec_accum: decimal digit check and acc*10+d step
module dec_accum (
    input  logic [31:0] acc_i,
    input  logic [7:0]  ch_i,
    output logic        digit_o,
    output logic [31:0] acc_o
);

    assign digit_o = (ch_i >= "0") && (ch_i <= "9");
    // Low nibble of an ASCII digit is its value.
    assign acc_o   = acc_i * 32'd10 + {28'd0, ch_i[3:0]};

endmodule

// File: rtl/input_arguments.sv
// input_arguments: parses "+MODE=<dec>" / "+FILE=<name>" byte stream into file/mode descriptors
module input_arguments
    import cfg_pkg::*;
#(
    parameter int NAME_MAX  = 255,
    parameter int MODE_DIGS = 9
) (
    input  logic              clk,
    input  logic              rst,
    input_arguments_if.slave  bus
);

    state_t      st_q, nxt_st;
    logic [31:0] acc_q, file_q, mode_q, acc_nx;
    logic [15:0] sum_q, sum_nx;
    logic [7:0]  len_q, len_nx, ndig_q;
    logic [2:0]  kidx_q;
    logic        mlive_q, flive_q, bad_q, cfg_q, err_q;
    logic        take, dig, m_hit, f_hit, key_done, mbad, fbad;

    assign take          = bus.arg_valid && !cfg_q;
    assign bus.arg_ready = !cfg_q;
    assign bus.file      = file_q;
    assign bus.mode      = mode_q;
    assign bus.cfg_valid = cfg_q;
    assign bus.err       = err_q;

    dec_accum u_dec (.acc_i(acc_q), .ch_i(bus.arg_data), .digit_o(dig), .acc_o(acc_nx));

    // Key matching and value-accumulation results for the byte on the bus
    always_comb begin
        m_hit    = mlive_q && (bus.arg_data == key_byte(KEY_MODE, kidx_q));
        f_hit    = flive_q && (bus.arg_data == key_byte(KEY_FILE, kidx_q));
        key_done = (kidx_q == 3'd4) && (m_hit || f_hit);
        mbad     = bad_q || !dig || (ndig_q == 8'(MODE_DIGS));
        fbad     = bad_q || (len_q == 8'(NAME_MAX));
        len_nx   = len_q + 8'd1;
        sum_nx   = sum_q + {8'd0, bus.arg_data};
        nxt_st   = bus.arg_last ? S_START :
                   (st_q == S_START) ? ((bus.arg_data == "+") ? S_KEY : S_SKIP) :
                   (st_q == S_KEY) ? (key_done ? (m_hit ? S_MVAL : S_FVAL) :
                                      (m_hit || f_hit) ? S_KEY : S_SKIP) :
                   st_q;
    end

    // Parser FSM with registered configuration outputs; args_end freezes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= S_START;
            acc_q   <= '0;
            len_q   <= '0;
            sum_q   <= '0;
            ndig_q  <= '0;
            kidx_q  <= '0;
            mlive_q <= 1'b1;
            flive_q <= 1'b1;
            bad_q   <= 1'b0;
            file_q  <= '0;
            mode_q  <= '0;
            cfg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (st_q == S_START) begin
                acc_q   <= '0;
                len_q   <= '0;
                sum_q   <= '0;
                ndig_q  <= '0;
                kidx_q  <= '0;
                mlive_q <= 1'b1;
                flive_q <= 1'b1;
                bad_q   <= 1'b0;
            end
            if (take) begin
                st_q <= nxt_st;
                case (st_q)
                    S_KEY: begin
                        kidx_q  <= kidx_q + 3'd1;
                        mlive_q <= m_hit;
                        flive_q <= f_hit;
                        if (bus.arg_last && key_done) err_q <= 1'b1;
                    end
                    S_MVAL: begin
                        acc_q  <= acc_nx;
                        ndig_q <= ndig_q + 8'd1;
                        bad_q  <= mbad;
                        if (bus.arg_last) begin
                            if (mbad) err_q <= 1'b1;
                            else mode_q <= acc_nx;
                        end
                    end
                    S_FVAL: begin
                        len_q <= len_nx;
                        sum_q <= sum_nx;
                        bad_q <= fbad;
                        if (bus.arg_last) begin
                            if (fbad) err_q <= 1'b1;
                            else file_q <= {1'b1, 7'd0, len_nx, sum_nx};
                        end
                    end
                    default: ;
                endcase
            end
            if (bus.args_end && !cfg_q) begin
                cfg_q <= 1'b1;
                st_q  <= S_START;
            end
        end
    end

endmodule

// File: tb/tb_input_arguments.sv
// tb_input_arguments: directed argument streams checked against a string-level model
module tb_input_arguments;
    import cfg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    input_arguments_if bus ();
    input_arguments dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] exp_file, exp_mode;
    logic        exp_cfg, exp_err;
    logic [7:0]  cur[$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    endtask

    function automatic bit has_key(input string k);
        if (cur.size() < 6) return 0;
        for (int i = 0; i < 6; i++) if (cur[i] != k[i]) return 0;
        return 1;
    endfunction

    // Interpret one complete argument string.
    task automatic close_arg();
        int          n;
        bit          ok;
        logic [31:0] v;
        logic [15:0] s;
        n = cur.size() - 6;
        if (has_key("+MODE=")) begin
            ok = (n >= 1) && (n <= 9);
            v = 0;
            for (int i = 6; i < cur.size(); i++) begin
                if (cur[i] < "0" || cur[i] > "9") ok = 0;
                v = v * 10 + 32'(cur[i] - "0");
            end
            if (ok) exp_mode = v; else exp_err = 1;
        end else if (has_key("+FILE=")) begin
            ok = (n >= 1) && (n <= 255);
            s = 0;
            for (int i = 6; i < cur.size(); i++) s = s + 16'(cur[i]);
            if (ok) exp_file = {1'b1, 7'd0, 8'(n), s}; else exp_err = 1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_file = 0;
            exp_mode = 0;
            exp_cfg  = 0;
            exp_err  = 0;
            cur.delete();
        end else begin
            if (bus.arg_valid && !exp_cfg) begin
                cur.push_back(bus.arg_data);
                if (bus.arg_last) begin
                    close_arg();
                    cur.delete();
                end
            end
            if (bus.args_end && !exp_cfg) begin
                exp_cfg = 1;
                cur.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("file", bus.file, exp_file);
            chk("mode", bus.mode, exp_mode);
            chk("err", {31'd0, bus.err}, {31'd0, exp_err});
            chk("cfg_valid", {31'd0, bus.cfg_valid}, {31'd0, exp_cfg});
            chk("arg_ready", {31'd0, bus.arg_ready}, {31'd0, !exp_cfg});
        end
    end

    task automatic send_arg(input string s, input bit close = 1, input bit with_end = 0);
        for (int i = 0; i < s.len(); i++) begin
            @(posedge clk); #1;
            bus.arg_valid = 1;
            bus.arg_data  = s[i];
            bus.arg_last  = close && (i == s.len() - 1);
            bus.args_end  = with_end && (i == s.len() - 1);
        end
        @(posedge clk); #1;
        bus.arg_valid = 0;
        bus.arg_last  = 0;
        bus.args_end  = 0;
    endtask

    task automatic send_end();
        @(posedge clk); #1;
        bus.args_end = 1;
        @(posedge clk); #1;
        bus.args_end = 0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic chk_reset_vals(input string n);
        chk({n, "_file"}, bus.file, 32'h0);
        chk({n, "_mode"}, bus.mode, 32'h0);
        chk({n, "_err"}, {31'd0, bus.err}, 32'h0);
        chk({n, "_cfg"}, {31'd0, bus.cfg_valid}, 32'h0);
        chk({n, "_ready"}, {31'd0, bus.arg_ready}, 32'h1);
    endtask

    initial begin
        string long_name;
        bus.arg_valid = 0;
        bus.arg_data  = 0;
        bus.arg_last  = 0;
        bus.args_end  = 0;
        #12;
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst = 0;

        send_arg("+MODE=1");
        send_end();
        chk("m1_mode", bus.mode, MODE_VERBOSE);
        chk("m1_file", bus.file, 32'h0);
        chk("m1_err", {31'd0, bus.err}, 32'h0);
        chk("m1_cfg", {31'd0, bus.cfg_valid}, 32'h1);
        chk("m1_ready", {31'd0, bus.arg_ready}, 32'h0);
        send_arg("+MODE=3");
        send_end();
        chk("after_cfg_mode", bus.mode, 32'd1);
        chk("after_cfg_ready", {31'd0, bus.arg_ready}, 32'h0);

        do_reset();
        send_arg("+FILE=ab");
        send_end();
        chk("fab_file", bus.file, 32'h8002_00C3);
        chk("fab_mode", bus.mode, 32'h0);

        do_reset();
        send_arg("+MODE=1x");
        chk("m1x_err", {31'd0, bus.err}, 32'h1);
        chk("m1x_mode", bus.mode, 32'h0);

        do_reset();
        send_arg("+FILE=");
        chk("fempty_err", {31'd0, bus.err}, 32'h1);
        chk("fempty_file", bus.file, 32'h0);

        do_reset();
        long_name = "+FILE=";
        for (int i = 0; i < 255; i++) long_name = {long_name, "a"};
        send_arg(long_name);
        chk("f255_file", bus.file, 32'h80FF_609F);
        chk("f255_err", {31'd0, bus.err}, 32'h0);
        long_name = {long_name, "a"};
        send_arg(long_name);
        chk("f256_err", {31'd0, bus.err}, 32'h1);
        chk("f256_file", bus.file, 32'h80FF_609F);

        do_reset();
        send_arg({"+FILE=", long_name.substr(6, long_name.len() - 1)});
        chk("f256only_err", {31'd0, bus.err}, 32'h1);
        chk("f256only_file", bus.file, 32'h0);

        do_reset();
        send_arg("+FOO=3");
        send_arg("+MODE=12");
        chk("foo_err", {31'd0, bus.err}, 32'h0);
        chk("foo_mode", bus.mode, 32'd12);

        do_reset();
        send_arg("+MODE=5");
        send_arg("+MODE=7");
        chk("last_wins", bus.mode, 32'd7);

        do_reset();
        send_arg("+MODE=123456789");
        chk("m9dig", bus.mode, 32'd123456789);
        send_arg("+MODE=1234567890");
        chk("m10dig_mode", bus.mode, 32'd123456789);
        chk("m10dig_err", {31'd0, bus.err}, 32'h1);

        do_reset();
        send_arg("+");
        send_arg("+MOD");
        send_arg("x+MODE=6");
        send_arg("+MODE=");
        chk("bare_err", {31'd0, bus.err}, 32'h1);
        chk("bare_mode", bus.mode, 32'h0);

        do_reset();
        send_arg("+MODE=4", 1, 1);
        chk("same_cycle_mode", bus.mode, 32'd4);
        chk("same_cycle_cfg", {31'd0, bus.cfg_valid}, 32'h1);

        do_reset();
        send_arg("+MODE=9");
        send_arg("+MODE=8", 0);
        send_end();
        chk("partial_mode", bus.mode, 32'd9);
        chk("partial_cfg", {31'd0, bus.cfg_valid}, 32'h1);

        do_reset();
        send_arg("+MODE=7");
        send_arg("+FILE=abc", 0);
        @(posedge clk); #3;
        rst = 1;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk); #1;
        rst = 0;
        send_arg("+FILE=abc");
        chk("post_rst_file", bus.file, 32'h8003_0126);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
